// File: rtl/bus_arbiter.sv
`default_nettype none
// bus_arbiter: two-master round-robin arbiter that holds the grant for a whole (burst) transaction.
// Optional watchdog: define ARB_TIMEOUT_EN to release hung transactions after TIMEOUT stalled cycles.
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W/8-1:0]   m0_dataena,
    input  logic [BURST_W-1:0]    m0_burstcount,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_valid,
    output logic                  m0_waitrequest,
    output logic                  m0_error,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W/8-1:0]   m1_dataena,
    input  logic [BURST_W-1:0]    m1_burstcount,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_valid,
    output logic                  m1_waitrequest,
    output logic                  m1_error,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic                  bus_read,
    output logic                  bus_write,
    output logic [DATA_W/8-1:0]   bus_dataena,
    output logic [BURST_W-1:0]    bus_burstcount,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_valid,
    input  logic                  bus_waitrequest,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [1:0]         grant_nx;
    logic               last_grant, last_nx;   // 0 = M0, 1 = M1
    logic [BURST_W-1:0] beats_left, beats_nx;
    logic               started, started_nx;   // a beat of the current command was accepted
    logic               done;

    logic               m0_req, m1_req;
    logic               pick;
    logic [BURST_W-1:0] pick_bc;
    logic               owner;
    logic               own_read, own_write, own_req;
    logic               progress, timeout;

    assign m0_req    = m0_read | m0_write;
    assign m1_req    = m1_read | m1_write;
    assign pick      = (m0_req && m1_req) ? !last_grant : m1_req;
    assign pick_bc   = pick ? m1_burstcount : m0_burstcount;
    assign owner     = grant[1];
    assign own_read  = owner ? m1_read : m0_read;
    // A master raising both read and write gets a read.
    assign own_write = !own_read && (owner ? m1_write : m0_write);
    assign own_req   = own_read | own_write;
    assign progress  = ((state == CMD) && own_req && !bus_waitrequest) ||
                       ((state == RDWAIT) && bus_valid);

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] watchdog;

    assign timeout = (state != IDLE) && !progress && (watchdog == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            watchdog <= '0;
        end else if ((state == IDLE) || progress || timeout) begin
            watchdog <= '0;
        end else begin
            watchdog <= watchdog + WD_W'(1);
        end
    end
`else
    logic unused_timeout;
    assign timeout        = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            beats_left <= '0;
            started    <= 1'b0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_nx;
            beats_left <= beats_nx;
            started    <= started_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        last_nx    = last_grant;
        beats_nx   = beats_left;
        started_nx = started;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_nx   = pick ? 2'b10 : 2'b01;
                    beats_nx   = (pick_bc == '0) ? BURST_W'(1) : pick_bc;
                    started_nx = 1'b0;
                    state_nx   = CMD;
                end
            end
            CMD: begin
                if (!own_req) begin
                    // Abandoned before completion: only charge the owner if it got a beat through.
                    state_nx = IDLE;
                    grant_nx = 2'b00;
                    if (started) begin
                        last_nx = owner;
                    end
                end else if (!bus_waitrequest) begin
                    started_nx = 1'b1;
                    if (own_write || bus_valid) begin
                        if (beats_left == BURST_W'(1)) begin
                            done = 1'b1;
                        end else begin
                            beats_nx = beats_left - BURST_W'(1);
                        end
                    end
                    if (own_read) begin
                        state_nx = RDWAIT;
                    end
                end
            end
            RDWAIT: begin
                if (bus_valid) begin
                    if (beats_left == BURST_W'(1)) begin
                        done = 1'b1;
                    end else begin
                        beats_nx = beats_left - BURST_W'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 2'b00;
            end
        endcase
        if (done || timeout) begin
            state_nx = IDLE;
            grant_nx = 2'b00;
            last_nx  = owner;
        end
    end

    always_comb begin
        bus_addr       = '0;
        bus_wdata      = '0;
        bus_dataena    = '0;
        bus_burstcount = '0;
        bus_read       = 1'b0;
        bus_write      = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_valid       = 1'b0;
        m1_valid       = 1'b0;
        m0_error       = 1'b0;
        m1_error       = 1'b0;
        if (state != IDLE) begin
            bus_addr       = owner ? m1_addr       : m0_addr;
            bus_wdata      = owner ? m1_wdata      : m0_wdata;
            bus_dataena    = owner ? m1_dataena    : m0_dataena;
            bus_burstcount = owner ? m1_burstcount : m0_burstcount;
            m0_valid       = bus_valid && !owner;
            m1_valid       = bus_valid && owner;
            m0_error       = timeout && !owner;
            m1_error       = timeout && owner;
        end
        if ((state == CMD) && !timeout) begin
            bus_read       = own_read;
            bus_write      = own_write;
            m0_waitrequest = owner || bus_waitrequest;
            m1_waitrequest = !owner || bus_waitrequest;
        end
    end

    assign m0_rdata = bus_rdata;
    assign m1_rdata = bus_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// tb_bus_arbiter: directed scenarios plus randomized traffic for bus_arbiter,
// checked every cycle against a transaction-level reference model.
module tb_bus_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int BEW = DW / 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  addr  [2];
    logic [DW-1:0]  wdata [2];
    logic           rd    [2];
    logic           wr    [2];
    logic [BEW-1:0] be    [2];
    logic [BW-1:0]  bc    [2];

    logic [DW-1:0]  m0_rdata, m1_rdata;
    logic           m0_valid, m1_valid, m0_waitrequest, m1_waitrequest, m0_error, m1_error;
    logic [AW-1:0]  bus_addr;
    logic [DW-1:0]  bus_wdata, bus_rdata;
    logic           bus_read, bus_write, bus_valid, bus_waitrequest;
    logic [BEW-1:0] bus_dataena;
    logic [BW-1:0]  bus_burstcount;
    logic [1:0]     grant;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_read(rd[0]), .m0_write(wr[0]),
        .m0_dataena(be[0]), .m0_burstcount(bc[0]), .m0_rdata(m0_rdata), .m0_valid(m0_valid),
        .m0_waitrequest(m0_waitrequest), .m0_error(m0_error),
        .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_read(rd[1]), .m1_write(wr[1]),
        .m1_dataena(be[1]), .m1_burstcount(bc[1]), .m1_rdata(m1_rdata), .m1_valid(m1_valid),
        .m1_waitrequest(m1_waitrequest), .m1_error(m1_error),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_read(bus_read), .bus_write(bus_write),
        .bus_dataena(bus_dataena), .bus_burstcount(bus_burstcount),
        .bus_rdata(bus_rdata), .bus_valid(bus_valid), .bus_waitrequest(bus_waitrequest),
        .grant(grant)
    );

    // Reference model: who owns the bus, how many beats remain, whether the command was accepted.
    int   owner;
    int   last_owner;
    int   left;
    bit   rdph;
    bit   done_m [2];
    int   checks = 0;
    int   errors = 0;
    int   cnt_v0, cnt_v1, cnt_w0low;
    logic [1:0] prev_grant;
    int   order [$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        owner      = -1;
        last_owner = 1;
        left       = 0;
        rdph       = 1'b0;
    endtask

    task automatic clear_counters();
        cnt_v0 = 0; cnt_v1 = 0; cnt_w0low = 0;
        prev_grant = 2'b00;
        order.delete();
    endtask

    function automatic int order_code();
        int c = 0;
        foreach (order[i]) c = c * 4 + order[i] + 1;
        return c;
    endfunction

    task automatic model_update();
        int o;
        if (rst) begin
            model_reset();
            return;
        end
        if (owner < 0) begin
            if (rd[0] || wr[0] || rd[1] || wr[1]) begin
                if ((rd[0] || wr[0]) && (rd[1] || wr[1])) o = 1 - last_owner;
                else o = (rd[1] || wr[1]) ? 1 : 0;
                owner = o;
                left  = (bc[o] == 0) ? 1 : int'(bc[o]);
                rdph  = 1'b0;
            end
        end else if (!rdph) begin
            if (!(rd[owner] || wr[owner])) begin
                owner = -1;
            end else if (!bus_waitrequest) begin
                if (rd[owner]) begin
                    rdph = 1'b1;
                    if (bus_valid) left--;
                end else begin
                    left--;
                end
            end
        end else if (bus_valid) begin
            left--;
        end
        if (owner >= 0 && left == 0) begin
            done_m[owner] = 1'b1;
            last_owner    = owner;
            owner         = -1;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [1:0]  eg, ew, ev;
        logic        ebr, ebw;
        logic [71:0] edp;
        eg = 2'b00; ew = 2'b11; ev = 2'b00; ebr = 1'b0; ebw = 1'b0; edp = '0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            ev[owner] = bus_valid;
            edp = {addr[owner], wdata[owner], be[owner], bc[owner]};
            if (!rdph) begin
                ebr = rd[owner];
                ebw = wr[owner] && !rd[owner];
                ew[owner] = bus_waitrequest;
            end
        end
        chk({tag, "_ctl"},   {grant, bus_read, bus_write}, {eg, ebr, ebw});
        chk({tag, "_wait"},  {m1_waitrequest, m0_waitrequest}, ew);
        chk({tag, "_valid"}, {m1_valid, m0_valid}, ev);
        chk({tag, "_dp"},    {bus_addr, bus_wdata, bus_dataena, bus_burstcount}, edp);
        chk({tag, "_rdata"}, {m1_rdata, m0_rdata}, {bus_rdata, bus_rdata});
        chk({tag, "_err"},   {m1_error, m0_error}, 2'b00);
        cnt_v0    += int'(m0_valid);
        cnt_v1    += int'(m1_valid);
        cnt_w0low += int'(!m0_waitrequest);
        if (grant != prev_grant && grant != 2'b00) order.push_back(grant[1] ? 1 : 0);
        prev_grant = grant;
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic step(input string tag);
        #1 compare_all(tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (done_m[i]) begin
                rd[i] = 1'b0; wr[i] = 1'b0; done_m[i] = 1'b0;
            end
        end
    endtask

    task automatic run_auto(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            bus_waitrequest = 1'b0;
            bus_valid       = rdph;
            bus_rdata       = $urandom;
            step(tag);
        end
    endtask

    initial begin
        rst = 1'b1; bus_waitrequest = 1'b1; bus_valid = 1'b0; bus_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0;
            be[i] = '0; bc[i] = '0; done_m[i] = 1'b0;
        end
        model_reset();
        clear_counters();
        @(negedge clk);
        step("reset");
        bus_valid = 1'b1;
        step("reset");
        bus_valid = 1'b0;
        rst = 1'b0;

        // Contention from reset: M0 wins the first tie
        clear_counters();
        rd[0] = 1'b1; rd[1] = 1'b1; bc[0] = 4'd1; bc[1] = 4'd1;
        addr[0] = 32'h0000_0100; addr[1] = 32'h0000_0200;
        run_auto("t2a", 10);
        chk("t2a_order", order_code(), 6);

        // M0 single write with two stalled cycles
        clear_counters();
        wr[0] = 1'b1; addr[0] = 32'h2000_0000; wdata[0] = 32'd150; be[0] = 4'hF; bc[0] = 4'd1;
        bus_waitrequest = 1'b1;
        step("t1"); step("t1"); step("t1");
        bus_waitrequest = 1'b0;
        step("t1");
        bus_waitrequest = 1'b1;
        step("t1");
        chk("t1_wait_low", cnt_w0low, 1);
        chk("t1_grant_idle", grant, 2'b00);

        // Contention again: M0 was last, so M1 wins
        clear_counters();
        rd[0] = 1'b1; rd[1] = 1'b1; bc[0] = 4'd1; bc[1] = 4'd1;
        run_auto("t2b", 10);
        chk("t2b_order", order_code(), 9);

        // M1 burst of 4 with gapped valids while M0 waits
        clear_counters();
        rd[1] = 1'b1; bc[1] = 4'd4; addr[1] = 32'h0000_0000;
        bus_waitrequest = 1'b0; bus_valid = 1'b0;
        step("t3");
        rd[0] = 1'b1; bc[0] = 4'd1;
        for (int i = 0; i < 24; i++) begin
            bus_waitrequest = 1'b0;
            bus_valid       = rdph && (i % 2 == 1);
            bus_rdata       = $urandom;
            step("t3");
        end
        chk("t3_m1_beats", cnt_v1, 4);
        chk("t3_m0_beats", cnt_v0, 1);
        chk("t3_order", order_code(), 9);

        // Read accepted with data in the same cycle; burstcount 0 means one beat
        clear_counters();
        rd[0] = 1'b1; bc[0] = 4'd0; bus_waitrequest = 1'b0; bus_valid = 1'b0;
        step("t4");
        bus_valid = 1'b1;
        step("t4");
        bus_valid = 1'b0;
        step("t4");
        chk("t4_beats", cnt_v0, 1);
        chk("t4_grant_idle", grant, 2'b00);

        // Asynchronous reset in the middle of a 3-beat read
        clear_counters();
        rd[0] = 1'b1; bc[0] = 4'd3; bus_waitrequest = 1'b0; bus_valid = 1'b0;
        step("t5"); step("t5");
        bus_valid = 1'b1;
        step("t5");
        bus_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk("t5_async", {grant, bus_read, m1_waitrequest, m0_waitrequest, m0_valid},
               {2'b00, 1'b0, 1'b1, 1'b1, 1'b0});
        rd[0] = 1'b0;
        model_reset();
        @(negedge clk);
        step("t5_rst");
        rst = 1'b0;
        clear_counters();
        rd[1] = 1'b1; bc[1] = 4'd1;
        run_auto("t5_after", 6);
        chk("t5_order", order_code(), 2);

        // Owner drops its write before any beat: last owner stays M1, so M0 wins the next tie
        clear_counters();
        wr[0] = 1'b1; bc[0] = 4'd2; bus_waitrequest = 1'b1;
        step("t6"); step("t6");
        wr[0] = 1'b0;
        step("t6"); step("t6");
        clear_counters();
        rd[0] = 1'b1; rd[1] = 1'b1; bc[0] = 4'd1; bc[1] = 4'd1;
        run_auto("t6_tie", 10);
        chk("t6_order", order_code(), 6);

        // Randomized traffic; masters hold each request until its transaction completes
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!rd[i] && !wr[i] && ($urandom_range(0, 3) == 0)) begin
                    rd[i]    = 1'($urandom_range(0, 1));
                    wr[i]    = !rd[i] || ($urandom_range(0, 7) == 0);
                    addr[i]  = $urandom;
                    wdata[i] = $urandom;
                    be[i]    = BEW'($urandom);
                    bc[i]    = BW'($urandom_range(0, 4));
                end
            end
            bus_waitrequest = ($urandom_range(0, 2) == 0);
            bus_valid       = 1'($urandom_range(0, 1));
            bus_rdata       = $urandom;
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
